ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit with a small instruction queue. It sits directly upstream of the decoder. It keeps the fetch PC and issues one word-aligned read at a time to the instruction cache. Returned instructions are buffered together with their PCs and handed to the decoder over a valid/ready handshake. A redirect from the back end (branch/jump resolution) flushes the queue and restarts fetch at a new PC.

## Interface
- QUEUE_DEPTH_LOG, default 2: the queue holds 2^QUEUE_DEPTH_LOG entries (default 4).
- RESET_PC, default 32'h0: first fetch address after reset.

- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  global ready; when low, the block pauses.
- ic_req_valid  out  1  read request to the icache, valid this cycle.
- ic_req_addr  out  32  request address; always has [1:0]=0.
- ic_resp_valid  in  1  icache returns a word this cycle; responses arrive in order, at most one outstanding.
- ic_resp_instr  in  32  returned instruction.
- dec_valid  out  1  queue head is valid.
- dec_pc  out  32  PC of the queue head.
- dec_instr  out  32  instruction at the queue head.
- dec_ready  in  1  decoder accepts the head this cycle.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] are ignored and forced to 0.

## Operation
- **State held:** fetch_pc (32b), req_pc (32b, address of the outstanding request), FSM state, queue storage of {pc, instr}, head and tail pointers (QUEUE_DEPTH_LOG bits, wrap naturally), count (QUEUE_DEPTH_LOG+1 bits).
- **FSM states:**
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response will be kept.
  - DISCARD: one request outstanding; its response will be dropped.
- **Request issue (combinational):** ic_req_valid = rdy_in & !rst_in & !redirect_valid & state==IDLE & count<DEPTH.
  - ic_req_addr = fetch_pc.
  - When ic_req_valid is high: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32), state<=WAIT.
- **Response in WAIT:** push {req_pc, ic_resp_instr} at tail, then state<=IDLE.
  - Space is guaranteed because count<DEPTH at issue, and count cannot grow while waiting.
- **Response in DISCARD:** the word is dropped and state<=IDLE.
- **Pop:** dec_valid = count!=0.
  - dec_pc and dec_instr are driven combinationally from the head entry.
  - The head is popped when dec_valid & dec_ready & rdy_in.
- **Simultaneous push and pop:** count is unchanged, and both pointers advance.
- **Redirect (highest priority, needs rdy_in high):**
  - Queue cleared: head=tail=0, count=0. A pop in the same cycle is ignored.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - No request is issued that cycle.
  - Next state: from IDLE → IDLE. From WAIT or DISCARD → IDLE if ic_resp_valid this cycle (response dropped), else DISCARD.
- **rdy_in low:** no state changes; ic_req_valid=0; pops are ignored. The icache is paused by the same signal, so it never asserts ic_resp_valid while rdy_in is low.
- **ic_resp_valid in IDLE:** a protocol error; ignored.

## Timing
- **Reset (rst_in high at a clock edge):**
  - state=IDLE, fetch_pc=RESET_PC, req_pc=0, count=0, head=tail=0.
  - Resulting outputs: dec_valid=0, dec_pc=0, dec_instr=0, ic_req_valid=0 while rst_in is high.
- **Reset mid-operation:** same values as above. An outstanding response that arrives after reset and before a new request is seen in IDLE and ignored.
- **First request:** ic_req_valid=1 with ic_req_addr=RESET_PC in the first cycle with rst_in low and rdy_in high.
- **Latency:** response at edge t → dec_valid=1 in cycle t+1.
- **Best-case throughput:** one instruction per 2 cycles with a 1-cycle icache (request, then response).
- **After redirect at edge t:** next request is to redirect_pc in cycle t+1 if the FSM went to IDLE. If it went to DISCARD, the request goes out the cycle after the discarded response.
- **Stability:** dec_pc and dec_instr hold stable while dec_valid=1 and no pop or redirect occurs.

## Test plan
- **Reset then fetch:** RESET_PC=0, 1-cycle icache returning 0x13,0x93,… → requests to 0x0,0x4,0x8 on alternate cycles; dec_pc/dec_instr = 0x0/0x13 then 0x4/0x93 in order.
- **Backpressure:** dec_ready=0 → after 4 responses count=4, dec_pc stays 0x0, and ic_req_valid stays 0. Then dec_ready=1 for one cycle → one pop, and the next request goes to 0x10.
- **Full push/pop:** count=3 with a response pending, and the pop and push land in the same cycle → count stays 3; the order of the popped and pushed PCs is preserved.
- **Redirect while WAIT:** redirect_pc=0x103 with no response that cycle → dec_valid=0 next cycle. The next response is dropped, then a request to 0x100. The first delivered entry is pc=0x100.
- **Redirect coincident with response:** redirect_pc=0x200 in the same cycle as ic_resp_valid → the response is dropped and the next request goes to 0x200 in the following cycle.
- **rdy_in low:** hold rdy_in=0 for 3 cycles with a non-empty queue and dec_ready=1 → no pops, no requests, all outputs unchanged. Resuming continues the exact prior sequence.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache read, responses queued with their PCs for the decoder.
// Response at edge t is visible to the decoder in cycle t+1; fetch stalls while the queue is full or rdy_in is low.
module ifetch #(
    parameter int          QUEUE_DEPTH_LOG = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_instr,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t                   state;
    logic [31:0]              fetch_pc;
    logic [31:0]              req_pc;
    entry_t                   queue [DEPTH];
    logic [QUEUE_DEPTH_LOG-1:0] head;
    logic [QUEUE_DEPTH_LOG-1:0] tail;
    logic [QUEUE_DEPTH_LOG:0]   count;

    logic not_full;
    logic push;
    logic pop;

    // count never exceeds DEPTH, so its MSB alone marks the full queue
    assign not_full     = !count[QUEUE_DEPTH_LOG];
    assign ic_req_valid = rdy_in & !rst_in & !redirect_valid & (state == S_IDLE) & not_full;
    assign ic_req_addr  = fetch_pc;

    assign push = rdy_in & !redirect_valid & (state == S_WAIT) & ic_resp_valid;
    assign pop  = dec_valid & dec_ready & rdy_in & !redirect_valid;

    assign dec_valid = (count != '0);
    assign dec_pc    = dec_valid ? queue[head].pc    : 32'h0;
    assign dec_instr = dec_valid ? queue[head].instr : 32'h0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC & ~32'h3;
            req_pc   <= 32'h0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (rdy_in) begin
            if (redirect_valid) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= redirect_pc & ~32'h3;
                // an in-flight read that has not returned yet must be swallowed later
                if (state == S_IDLE || ic_resp_valid) begin
                    state <= S_IDLE;
                end else begin
                    state <= S_DISCARD;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ic_req_valid) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ic_resp_valid) begin
                            state <= S_IDLE;
                        end
                    end
                    S_DISCARD: begin
                        if (ic_resp_valid) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            queue[tail] <= '{pc: req_pc, instr: ic_resp_instr};
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Directed cycle-by-cycle bench for ifetch: each row gives one cycle's inputs and the outputs expected before its edge.
module tb_ifetch;
    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_instr;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_total = 0;
    int n_pass  = 0;

    ifetch dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_instr  (ic_resp_instr),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] ri;
        logic        dr;
        logic        xv;
        logic [31:0] xpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl[$];

    // icache contents: word at address a holds 0x13 + a*0x20 (0x13, 0x93, 0x113, ...)
    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'h13 + (a << 5);
    endfunction

    function automatic vec_t v(input logic rst, input logic rdy, input logic rv, input logic [31:0] ri,
                               input logic dr, input logic xv, input logic [31:0] xpc,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_dv, input logic [31:0] e_pc, input logic [31:0] e_ins);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.rv = rv; r.ri = ri; r.dr = dr; r.xv = xv; r.xpc = xpc;
        r.e_req = e_req; r.e_addr = e_addr; r.e_dv = e_dv; r.e_pc = e_pc; r.e_ins = e_ins;
        return r;
    endfunction

    task automatic chk(input string name, input int step_no, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, step_no, act, exp);
        end
    endtask

    int step_no = 0;

    // drive one cycle of inputs after the falling edge, check outputs before the rising edge
    task automatic step(input vec_t t);
        @(negedge clk_in);
        rst_in         = t.rst;
        rdy_in         = t.rdy;
        ic_resp_valid  = t.rv;
        ic_resp_instr  = t.ri;
        dec_ready      = t.dr;
        redirect_valid = t.xv;
        redirect_pc    = t.xpc;
        #2;
        chk("ic_req_valid", step_no, {31'b0, ic_req_valid}, {31'b0, t.e_req});
        if (t.e_req) chk("ic_req_addr", step_no, ic_req_addr, t.e_addr);
        chk("dec_valid", step_no, {31'b0, dec_valid}, {31'b0, t.e_dv});
        if (t.e_dv || t.rst) begin
            chk("dec_pc", step_no, dec_pc, t.e_pc);
            chk("dec_instr", step_no, dec_instr, t.e_ins);
        end
        step_no++;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; ic_resp_valid = 1'b0; ic_resp_instr = 32'h0;
        dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk_in);

        //             rst rdy rv ri            dr xv xpc  | req addr    dv pc     instr
        tbl.push_back(v(1, 1, 0, 0,            0, 0, 0,     0, 0,       0, 0,     0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     1, 32'h0,   0, 0,     0));
        tbl.push_back(v(0, 1, 1, ins(32'h0),   0, 0, 0,     0, 0,       0, 0,     0));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 0,     1, 32'h4,   1, 32'h0, ins(32'h0)));
        tbl.push_back(v(0, 1, 1, ins(32'h4),   1, 0, 0,     0, 0,       0, 0,     0));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 0,     1, 32'h8,   1, 32'h4, ins(32'h4)));
        tbl.push_back(v(0, 1, 1, ins(32'h8),   0, 0, 0,     0, 0,       0, 0,     0));
        // decoder stalled: queue fills to four entries, head stays at 0x8
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     1, 32'hC,   1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 1, ins(32'hC),   0, 0, 0,     0, 0,       1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     1, 32'h10,  1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 1, ins(32'h10),  0, 0, 0,     0, 0,       1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     1, 32'h14,  1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 1, ins(32'h14),  0, 0, 0,     0, 0,       1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     0, 0,       1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     0, 0,       1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 0,     0, 0,       1, 32'h8, ins(32'h8)));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,     1, 32'h18,  1, 32'hC, ins(32'hC)));
        // push and pop land together with three entries queued
        tbl.push_back(v(0, 1, 1, ins(32'h18),  1, 0, 0,     0, 0,       1, 32'hC, ins(32'hC)));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 0,     1, 32'h1C,  1, 32'h10, ins(32'h10)));
        tbl.push_back(v(0, 1, 1, ins(32'h1C),  1, 0, 0,     0, 0,       1, 32'h14, ins(32'h14)));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 0,     1, 32'h20,  1, 32'h18, ins(32'h18)));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 0,     0, 0,       1, 32'h1C, ins(32'h1C)));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // redirect while a read to 0x20 is outstanding: its late response is dropped
        step(v(0, 1, 0, 0,             0, 1, 32'h103, 0, 0,      0, 0,       0));
        step(v(0, 1, 0, 0,             0, 0, 0,       0, 0,      0, 0,       0));
        step(v(0, 1, 1, ins(32'h20),   0, 0, 0,       0, 0,      0, 0,       0));
        step(v(0, 1, 0, 0,             0, 0, 0,       1, 32'h100, 0, 0,      0));
        step(v(0, 1, 1, ins(32'h100),  0, 0, 0,       0, 0,      0, 0,       0));
        step(v(0, 1, 0, 0,             0, 0, 0,       1, 32'h104, 1, 32'h100, ins(32'h100)));

        // redirect in the same cycle as the response
        step(v(0, 1, 1, ins(32'h104),  0, 1, 32'h200, 0, 0,      1, 32'h100, ins(32'h100)));
        step(v(0, 1, 0, 0,             0, 0, 0,       1, 32'h200, 0, 0,      0));
        step(v(0, 1, 1, ins(32'h200),  0, 0, 0,       0, 0,      0, 0,       0));
        step(v(0, 1, 0, 0,             0, 0, 0,       1, 32'h204, 1, 32'h200, ins(32'h200)));
        step(v(0, 1, 1, ins(32'h204),  0, 0, 0,       0, 0,      1, 32'h200, ins(32'h200)));

        // global stall with a non-empty queue and the decoder ready
        for (int i = 0; i < 3; i++) begin
            step(v(0, 0, 0, 0,         1, 0, 0,       0, 0,      1, 32'h200, ins(32'h200)));
        end
        step(v(0, 1, 0, 0,             0, 0, 0,       1, 32'h208, 1, 32'h200, ins(32'h200)));
        step(v(0, 0, 0, 0,             1, 0, 0,       0, 0,      1, 32'h200, ins(32'h200)));
        step(v(0, 1, 1, ins(32'h208),  1, 0, 0,       0, 0,      1, 32'h200, ins(32'h200)));
        step(v(0, 1, 0, 0,             1, 0, 0,       1, 32'h20C, 1, 32'h204, ins(32'h204)));
        step(v(0, 1, 0, 0,             1, 0, 0,       0, 0,      1, 32'h208, ins(32'h208)));
        step(v(0, 1, 0, 0,             0, 0, 0,       0, 0,      0, 0,       0));

        // reset with a read outstanding; the stale word arrives while idle and is ignored
        step(v(1, 1, 0, 0,             0, 0, 0,       0, 0,      0, 0,       0));
        step(v(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0,       1, 32'h0,  0, 0,       0));
        step(v(0, 1, 1, ins(32'h0),    0, 0, 0,       0, 0,      0, 0,       0));
        step(v(0, 1, 0, 0,             0, 0, 0,       1, 32'h4,  1, 32'h0,   ins(32'h0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
